// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu: single-cycle MIPS subset core with combinational instruction and data memory ports.
// Optional jal/jr support is enabled by defining MIPS_JAL_JR_EN.
module mips_single_cycle_cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_adr,
  input  logic [31:0] inst,
  output logic [31:0] data_adr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        mem_read,
  output logic        mem_write
);
  logic [31:0] pc_q, pc_d, pc4, rs_v, rt_v, sext, alu_b, alu_res, wd;
  logic [31:0] rf_q [32];
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wa;
  logic        is_r, r_add, r_sub, r_and, r_or, r_slt;
  logic        i_addi, i_slti, i_lw, i_sw, i_beq, i_j, is_jal, is_jr, we;
  assign op   = inst[31:26];
  assign fn   = inst[5:0];
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign rd   = inst[15:11];
  assign sext = {{16{inst[15]}}, inst[15:0]};
  assign pc4  = pc_q + 32'd4;
  assign rs_v = rf_q[rs];
  assign rt_v = rf_q[rt];
  assign is_r   = op == 6'b000000;
  assign r_add  = is_r && fn == 6'b100000;
  assign r_sub  = is_r && fn == 6'b100010;
  assign r_and  = is_r && fn == 6'b100100;
  assign r_or   = is_r && fn == 6'b100101;
  assign r_slt  = is_r && fn == 6'b101010;
  assign i_addi = op == 6'b001000;
  assign i_slti = op == 6'b001010;
  assign i_lw   = op == 6'b100011;
  assign i_sw   = op == 6'b101011;
  assign i_beq  = op == 6'b000100;
  assign i_j    = op == 6'b000010;
`ifdef MIPS_JAL_JR_EN
  assign is_jal = op == 6'b000011;
  assign is_jr  = is_r && fn == 6'b001000;
`else
  assign is_jal = 1'b0;
  assign is_jr  = 1'b0;
`endif
  always_comb begin
    alu_b   = is_r ? rt_v : sext;
    alu_res = r_sub ? rs_v - alu_b :
              r_and ? rs_v & alu_b :
              r_or  ? rs_v | alu_b :
              (r_slt || i_slti) ? {31'd0, $signed(rs_v) < $signed(alu_b)} :
              rs_v + alu_b;
    we = r_add || r_sub || r_and || r_or || r_slt || i_addi || i_slti || i_lw || is_jal;
    wa = is_r ? rd : is_jal ? 5'd31 : rt;
    wd = i_lw ? data_out : is_jal ? pc4 : alu_res;
    pc_d = (i_j || is_jal) ? {pc4[31:28], inst[25:0], 2'b00} :
           (i_beq && rs_v == rt_v) ? pc4 + {sext[29:0], 2'b00} :
           is_jr ? rs_v : pc4;
  end
  // rf_q[0] is never written, so r0 reads zero without a read-port mux
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      if (we && wa != 5'd0) rf_q[wa] <= wd;
    end
  assign inst_adr  = pc_q;
  assign data_adr  = alu_res;
  assign data_in   = rt_v;
  assign mem_read  = rst && i_lw;
  assign mem_write = rst && i_sw;
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// tb_mips_single_cycle_cpu: directed program bench with behavioural instruction and data memories.
module tb_mips_single_cycle_cpu;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] inst_adr, inst, data_adr, data_out, data_in;
  logic mem_read, mem_write;
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int checks = 0, errors = 0;
  mips_single_cycle_cpu dut (
    .clk(clk), .rst(rst), .inst_adr(inst_adr), .inst(inst), .data_adr(data_adr),
    .data_out(data_out), .data_in(data_in), .mem_read(mem_read), .mem_write(mem_write)
  );
  always #5 clk = ~clk;
  assign inst     = imem[inst_adr[7:2]];
  assign data_out = dmem[data_adr[5:2]];
  always @(posedge clk) if (mem_write) dmem[data_adr[5:2]] <= data_in;
  function automatic logic [31:0] ri(input logic [4:0] s, t, d, input logic [5:0] f);
    return {6'b000000, s, t, d, 5'd0, f};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] m);
    return {o, s, t, m};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    imem[0] = ii(6'h2B, 5'd0, 5'd0, 16'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", inst_adr, 32'd0);
    chk("rst_mw", {31'd0, mem_write}, 32'd0);
    imem[0] = ii(6'h23, 5'd0, 5'd0, 16'd0);
    #1 chk("rst_mr", {31'd0, mem_read}, 32'd0);
    imem[0]  = ii(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = ii(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2]  = ri(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3]  = ri(5'd2, 5'd1, 5'd4, 6'h2A);
    imem[4]  = ii(6'h04, 5'd1, 5'd1, 16'd2);
    imem[5]  = ii(6'h08, 5'd0, 5'd1, 16'd99);
    imem[6]  = ii(6'h08, 5'd0, 5'd1, 16'd99);
    imem[7]  = ii(6'h04, 5'd1, 5'd2, 16'd5);
    imem[8]  = 32'h0800_0010;
    imem[16] = ii(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[17] = ii(6'h23, 5'd0, 5'd5, 16'd8);
    imem[18] = ii(6'h2B, 5'd0, 5'd5, 16'd12);
    imem[19] = ii(6'h08, 5'd0, 5'd0, 16'd7);
    imem[20] = ii(6'h2B, 5'd0, 5'd0, 16'd0);
    imem[21] = ii(6'h2B, 5'd0, 5'd3, 16'd0);
    imem[22] = ii(6'h2B, 5'd0, 5'd4, 16'd0);
    imem[23] = ri(5'd1, 5'd2, 5'd6, 6'h22);
    imem[24] = ri(5'd1, 5'd2, 5'd7, 6'h25);
    imem[25] = ri(5'd1, 5'd2, 5'd8, 6'h24);
    imem[26] = ii(6'h0A, 5'd2, 5'd9, 16'd0);
    imem[27] = ii(6'h3F, 5'd0, 5'd1, 16'd1);
    imem[28] = ri(5'd0, 5'd0, 5'd1, 6'h3F);
    imem[29] = ii(6'h2B, 5'd0, 5'd1, 16'd0);
    imem[30] = ii(6'h08, 5'd0, 5'd1, 16'd9);
    @(negedge clk) rst = 1'b1;
    chk("pc0", inst_adr, 32'h00);
    chk("addi_pos", data_adr, 32'd5);
    step; chk("pc4", inst_adr, 32'h04);
    chk("addi_neg", data_adr, 32'hFFFF_FFFD);
    step; chk("pc8", inst_adr, 32'h08);
    chk("add_wrap", data_adr, 32'd2);
    step; chk("slt", data_adr, 32'd1);
    step; chk("pc_beq", inst_adr, 32'h10);
    step; chk("beq_taken", inst_adr, 32'h1C);
    step; chk("beq_not", inst_adr, 32'h20);
    step; chk("jump", inst_adr, 32'h40);
    chk("sw_mw", {31'd0, mem_write}, 32'd1);
    chk("sw_mr", {31'd0, mem_read}, 32'd0);
    chk("sw_adr", data_adr, 32'd8);
    chk("sw_data", data_in, 32'd5);
    step; chk("lw_mr", {31'd0, mem_read}, 32'd1);
    chk("lw_mw", {31'd0, mem_write}, 32'd0);
    chk("lw_adr", data_adr, 32'd8);
    step; chk("lw_r5", data_in, 32'd5);
    chk("sw_mem", dmem[2], 32'd5);
    step; chk("addi_r0", data_adr, 32'd7);
    step; chk("r0_zero", data_in, 32'd0);
    step; chk("r3", data_in, 32'd2);
    step; chk("r4", data_in, 32'd1);
    step; chk("sub", data_adr, 32'd8);
    step; chk("or", data_adr, 32'hFFFF_FFFD);
    step; chk("and", data_adr, 32'd5);
    step; chk("slti", data_adr, 32'd1);
    chk("slti_mw", {31'd0, mem_write}, 32'd0);
    step; chk("badop_pc", inst_adr, 32'h6C);
    chk("badop_mem", {30'd0, mem_read, mem_write}, 32'd0);
    step; chk("badfn_pc", inst_adr, 32'h70);
    step; chk("nop_keep_r1", data_in, 32'd5);
    step; chk("pc78", inst_adr, 32'h78);
    #2 rst = 1'b0;
    #1 chk("async_rst_pc", inst_adr, 32'd0);
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    imem[2]  = 32'h0C00_0010;
    imem[3]  = ii(6'h2B, 5'd0, 5'd31, 16'd0);
    imem[4]  = ii(6'h2B, 5'd0, 5'd1, 16'd0);
    imem[16] = ri(5'd31, 5'd0, 5'd0, 6'h08);
    @(negedge clk); chk("hold_pc", inst_adr, 32'd0);
    chk("hold_mw", {31'd0, mem_write}, 32'd0);
    rst = 1'b1;
    step; chk("b_pc4", inst_adr, 32'h04);
    step; chk("b_pc8", inst_adr, 32'h08);
`ifdef MIPS_JAL_JR_EN
    step; chk("jal", inst_adr, 32'h40);
    step; chk("jr", inst_adr, 32'h0C);
    chk("r31", data_in, 32'h0C);
`else
    step; chk("jal_nop", inst_adr, 32'h0C);
    chk("r31_zero", data_in, 32'd0);
`endif
    step; chk("rst_clr_r1", data_in, 32'd0);
    chk("b_pc10", inst_adr, 32'h10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_single_cycle_cpu.md
MIPS_SINGLE_CYCLE_CPU -- requirements
Module: mips_single_cycle_cpu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port inst_adr, output, 32 bits: byte address of the current instruction (PC).
REQ-004 SHALL have port inst, input, 32 bits: instruction word from combinational instruction memory.
REQ-005 SHALL have port data_adr, output, 32 bits: data-memory byte address (ALU result).
REQ-006 SHALL have port data_out, input, 32 bits: read data returned by data memory (combinational read).
REQ-007 SHALL have port data_in, output, 32 bits: store data to data memory (rt register value).
REQ-008 SHALL have port mem_read, output, 1 bit: high only for lw.
REQ-009 SHALL have port mem_write, output, 1 bit: high only for sw; memory writes on the clk rising edge.

Function
REQ-010 SHALL execute one instruction per clk cycle; PC, register file and memory write all commit on the same rising edge.
REQ-011 SHALL contain a 32x32 register file with 2 combinational read ports and 1 synchronous write port; r0 reads 0 always and writes to r0 are discarded.
REQ-012 SHALL decode R-type (opcode 000000) funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed); result written to rd.
REQ-013 SHALL decode I-type: addi 001000, slti 001010 (sign-extended imm, result to rt); lw 100011 (rt <= data_out at address rs+sext(imm)); sw 101011 (data_in = rt, data_adr = rs+sext(imm)); beq 000100.
REQ-014 SHALL decode j 000010: next PC = {PC+4[31:28], inst[25:0], 2'b00}.
REQ-015 beq SHALL set next PC = PC+4+(sext(imm)<<2) when rs==rt, else PC+4.
REQ-016 Arithmetic SHALL be 32-bit two's complement with wrap-around; overflow ignored and causes no exception.
REQ-017 Any unrecognised opcode or funct SHALL act as a nop: PC+4, with no register write and no memory access.
REQ-018 mem_read and mem_write SHALL never be high together; both SHALL be 0 for every instruction other than lw and sw.
REQ-019 data_adr SHALL always carry the ALU result, and data_in SHALL always carry the rt value, regardless of opcode.

Reset
REQ-020 While rst=0: PC=0 (inst_adr=0), all registers=0, mem_read=0, mem_write=0, and no register write occurs.
REQ-021 Reset assertion mid-instruction SHALL abort that instruction with no state committed.
REQ-022 After rst rises, the first fetch SHALL be from address 0 on the next rising edge.

Configuration
REQ-023 With macro MIPS_JAL_JR_EN defined: jal (opcode 000011) SHALL write PC+4 to r31 and jump as j; jr (R-type, funct 001000) SHALL set next PC = rs.
REQ-024 Without MIPS_JAL_JR_EN: jal and jr SHALL execute as nops per REQ-017.

Verification
REQ-025 Reset, then release -> inst_adr=0, then 4, 8, ... on successive edges; mem_read=mem_write=0 during reset.
REQ-026 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; a write to r0 leaves r0=0.
REQ-027 sw r1,8(r0) then lw r5,8(r0) -> sw cycle: mem_write=1, data_adr=8, data_in=5; lw cycle: mem_read=1, r5=5.
REQ-028 beq r1,r1,+2 at PC 0x10 -> next inst_adr=0x1C; beq r1,r2 (r1!=r2) -> next inst_adr=0x14.
REQ-029 j 0x40 (inst[25:0]=0x10) at PC 0x20 -> next inst_adr=0x40.
REQ-030 With MIPS_JAL_JR_EN, jal 0x40 at PC 0x8, then jr r31 -> r31=0xC, PC returns to 0xC; without the macro -> PC advances by 4 at each instruction.
